pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_sync_edge.sv | 45 ++++
 rtl/pwm_capture.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: measurement FSM states and default timing constants.
// Imported by pwm_capture (and by the pwm generator / fade blocks).
package pwm_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

    // Nominal PWM period in clk cycles (100 us at 12 MHz)
    localparam int unsigned PWM_INTERVAL_DEFAULT = 1200;
    // Edge timeout in clk cycles (two nominal periods)
    localparam int unsigned MAX_PERIOD_DEFAULT   = 2400;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus a third flop for edge detection, with registered
// single-cycle rise/fall strobes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   level      : synchronized level (third flop)
//   rise, fall : one-cycle registered edge strobes, mutually exclusive
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       s1;
    logic       s2;
    logic       s3;
    // Fills with ones after reset; edges are only trusted once s3 holds a
    // real sample, so an input already high at reset release is not a rise.
    logic [2:0] vld;

    // Synchronizer chain and edge strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            vld  <= 3'b000;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s3   <= s2;
            vld  <= {vld[1:0], 1'b1};
            rise <= s2 & ~s3 & vld[2];
            fall <= ~s2 & s3 & vld[2];
        end
    end

    assign level = s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rising-to-rising period of pwm_in and
// publishes them with a one-cycle duty_valid strobe; flags stuck inputs.
// Ports:
//   clk, rst_n : 12 MHz clock, asynchronous active-low reset
//   pwm_in     : asynchronous PWM input, active-high
//   duty       : measured high time in cycles, clamped to PWM_INTERVAL-1
//   period     : measured period in cycles, 0 on timeout
//   duty_valid : one-cycle strobe, duty/period/stuck updated with it
//   stuck      : last result came from an edge timeout
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
    parameter int unsigned MAX_PERIOD   = MAX_PERIOD_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pwm_in,
    output logic [$clog2(PWM_INTERVAL)-1:0]  duty,
    output logic [$clog2(MAX_PERIOD+1)-1:0]  period,
    output logic                             duty_valid,
    output logic                             stuck
);

    localparam int unsigned DUTY_W = $clog2(PWM_INTERVAL);
    localparam int unsigned CNT_W  = $clog2(MAX_PERIOD + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX      = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_MAX     = DUTY_W'(PWM_INTERVAL - 1);
    localparam logic [CNT_W-1:0]  DUTY_MAX_CNT = CNT_W'(PWM_INTERVAL - 1);

    logic rise;
    logic fall;
    // Level is exported by the sync block for other users; not needed here.
    logic level_unused;

    pwm_state_e        state,      state_d;
    logic [CNT_W-1:0]  high_cnt,   high_cnt_d;
    logic [CNT_W-1:0]  per_cnt,    per_cnt_d;
    logic [CNT_W-1:0]  high_inc;
    logic [CNT_W-1:0]  per_inc;
    logic [DUTY_W-1:0] duty_d;
    logic [CNT_W-1:0]  period_d;
    logic              duty_valid_d;
    logic              stuck_d;

    pwm_sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .level (level_unused),
        .rise  (rise),
        .fall  (fall)
    );

    // Saturating increments
    assign high_inc = (high_cnt < CNT_MAX) ? high_cnt + CNT_ONE : high_cnt;
    assign per_inc  = (per_cnt  < CNT_MAX) ? per_cnt  + CNT_ONE : per_cnt;

    // State, counters and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            high_cnt   <= '0;
            per_cnt    <= '0;
            duty       <= '0;
            period     <= '0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            state      <= state_d;
            high_cnt   <= high_cnt_d;
            per_cnt    <= per_cnt_d;
            duty       <= duty_d;
            period     <= period_d;
            duty_valid <= duty_valid_d;
            stuck      <= stuck_d;
        end
    end

    // Next-state, counter and result logic
    always_comb begin
        state_d      = state;
        high_cnt_d   = high_cnt;
        per_cnt_d    = per_cnt;
        duty_d       = duty;
        period_d     = period;
        duty_valid_d = 1'b0;
        stuck_d      = stuck;

        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = CNT_ONE;
                    per_cnt_d  = CNT_ONE;
                end
            end
            HIGH: begin
                // The fall cycle itself is low time, so high_cnt holds.
                if (fall) begin
                    state_d   = LOW;
                    per_cnt_d = per_inc;
                end else if (per_cnt == CNT_MAX) begin
                    state_d      = IDLE;
                    high_cnt_d   = '0;
                    per_cnt_d    = '0;
                    duty_d       = DUTY_MAX;
                    period_d     = '0;
                    stuck_d      = 1'b1;
                    duty_valid_d = 1'b1;
                end else begin
                    high_cnt_d = high_inc;
                    per_cnt_d  = per_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d      = HIGH;
                    high_cnt_d   = CNT_ONE;
                    per_cnt_d    = CNT_ONE;
                    duty_d       = (high_cnt > DUTY_MAX_CNT) ? DUTY_MAX : DUTY_W'(high_cnt);
                    period_d     = per_cnt;
                    stuck_d      = 1'b0;
                    duty_valid_d = 1'b1;
                end else if (per_cnt == CNT_MAX) begin
                    state_d      = IDLE;
                    high_cnt_d   = '0;
                    per_cnt_d    = '0;
                    duty_d       = '0;
                    period_d     = '0;
                    stuck_d      = 1'b1;
                    duty_valid_d = 1'b1;
                end else begin
                    per_cnt_d = per_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
